// File: rtl/can_bit_tx.sv
// rtl/can_bit_tx.sv - CAN bit-level transmitter with leading-region stuffing and mid-bit readback
module can_bit_tx #(
    parameter int MAX_BITS = 128,
    parameter int LEN_W    = 8
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic [22:0]         bitPeriod,
    input  logic [MAX_BITS-1:0] frameData,
    input  logic [LEN_W-1:0]    frameLen,
    input  logic [LEN_W-1:0]    stuffLen,
    input  logic                txValid,
    output logic                txReady,
    input  logic                rxIn,
    output logic                dOut,
    output logic                bitStrobe,
    output logic                txDone,
    output logic                bitError
);

    typedef enum logic [1:0] {IDLE, SEND, STUFF} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);

    state_t              state, state_nxt;
    logic [MAX_BITS-1:0] sh, sh_nxt;
    logic [22:0]         period, period_nxt;
    logic [22:0]         cnt, cnt_nxt;
    logic [LEN_W-1:0]    flen, flen_nxt;
    logic [LEN_W-1:0]    slen, slen_nxt;
    logic [LEN_W-1:0]    idx, idx_nxt;
    logic [2:0]          run, run_nxt;
    logic                dout_q, dout_nxt;
    logic                strobe_nxt, done_nxt, err_nxt;
    logic [LEN_W-1:0]    eff_len, eff_stuff;
    logic                last_cycle, sample;

    assign eff_len    = (frameLen > MAX_LEN) ? MAX_LEN : frameLen;
    assign eff_stuff  = (stuffLen > eff_len) ? eff_len : stuffLen;
    assign last_cycle = (cnt == period - 23'd1);
    assign sample     = (cnt == (period >> 1));

    // sh[0] is the data bit currently on the line (or just before a stuff bit);
    // run counts the current run including the bit being driven.
    always_comb begin
        state_nxt  = state;
        sh_nxt     = sh;
        period_nxt = period;
        cnt_nxt    = cnt;
        flen_nxt   = flen;
        slen_nxt   = slen;
        idx_nxt    = idx;
        run_nxt    = run;
        dout_nxt   = dout_q;
        strobe_nxt = 1'b0;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                dout_nxt = 1'b1;
                if (txValid && eff_len != '0) begin
                    state_nxt  = SEND;
                    sh_nxt     = frameData;
                    period_nxt = (bitPeriod == 23'd0) ? 23'd1 : bitPeriod;
                    flen_nxt   = eff_len;
                    slen_nxt   = eff_stuff;
                    cnt_nxt    = '0;
                    idx_nxt    = '0;
                    run_nxt    = (eff_stuff != '0) ? 3'd1 : 3'd0;
                    dout_nxt   = frameData[0];
                    strobe_nxt = 1'b1;
                end
            end
            default: begin
                if (sample && (rxIn != dout_q)) begin
                    state_nxt = IDLE;
                    dout_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                end else if (!last_cycle) begin
                    cnt_nxt = cnt + 23'd1;
                end else if (state == SEND && run == 3'd5) begin
                    state_nxt  = STUFF;
                    dout_nxt   = ~dout_q;
                    run_nxt    = 3'd1;
                    cnt_nxt    = '0;
                    strobe_nxt = 1'b1;
                end else if (idx == flen - LEN_W'(1)) begin
                    state_nxt = IDLE;
                    dout_nxt  = 1'b1;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt  = SEND;
                    idx_nxt    = idx + LEN_W'(1);
                    sh_nxt     = sh >> 1;
                    dout_nxt   = sh[1];
                    cnt_nxt    = '0;
                    strobe_nxt = 1'b1;
                    if (idx_nxt < slen)
                        run_nxt = (sh[1] == dout_q) ? run + 3'd1 : 3'd1;
                    else
                        run_nxt = 3'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            sh        <= '0;
            period    <= 23'd1;
            cnt       <= '0;
            flen      <= '0;
            slen      <= '0;
            idx       <= '0;
            run       <= '0;
            dout_q    <= 1'b1;
            bitStrobe <= 1'b0;
            txDone    <= 1'b0;
            bitError  <= 1'b0;
        end else begin
            state     <= state_nxt;
            sh        <= sh_nxt;
            period    <= period_nxt;
            cnt       <= cnt_nxt;
            flen      <= flen_nxt;
            slen      <= slen_nxt;
            idx       <= idx_nxt;
            run       <= run_nxt;
            dout_q    <= dout_nxt;
            bitStrobe <= strobe_nxt;
            txDone    <= done_nxt;
            bitError  <= err_nxt;
        end
    end

    assign dOut    = dout_q;
    assign txReady = (state == IDLE);

endmodule

// File: tb/tb_can_bit_tx.sv
// tb/tb_can_bit_tx.sv - bench for can_bit_tx: vector table with bit scoreboard plus corner sequences
module tb_can_bit_tx;

    logic         clk = 1'b0;
    logic         resetN;
    logic [22:0]  bitPeriod;
    logic [127:0] frameData;
    logic [7:0]   frameLen;
    logic [7:0]   stuffLen;
    logic         txValid;
    logic         txReady;
    logic         dOut;
    logic         bitStrobe;
    logic         txDone;
    logic         bitError;
    logic         rx_force;
    logic         rx_val;
    wire          rx_line = rx_force ? rx_val : dOut;

    int total = 0;
    int bad   = 0;
    logic sb[$];

    typedef struct {
        logic [22:0]  bp;
        logic [127:0] data;
        logic [7:0]   len;
        logic [7:0]   slen;
        int           exp_n;
        logic [159:0] exp_bits;
    } vec_t;

    vec_t tv[8];

    can_bit_tx #(.MAX_BITS(128), .LEN_W(8)) dut (
        .clk(clk), .resetN(resetN), .bitPeriod(bitPeriod), .frameData(frameData),
        .frameLen(frameLen), .stuffLen(stuffLen), .txValid(txValid), .txReady(txReady),
        .rxIn(rx_line), .dOut(dOut), .bitStrobe(bitStrobe), .txDone(txDone), .bitError(bitError)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int   pe, strobes, hold_err, done_c;
        logic cur;
        pe = (v.bp == 0) ? 1 : int'(v.bp);
        sb.delete();
        @(negedge clk);
        check($sformatf("v%0d_ready", id), txReady, 1);
        bitPeriod = v.bp; frameData = v.data; frameLen = v.len; stuffLen = v.slen;
        txValid = 1'b1;
        for (int j = 0; j < v.exp_n; j++) sb.push_back(v.exp_bits[j]);
        @(posedge clk);
        #1 txValid = 1'b0;
        strobes = 0; hold_err = 0; done_c = -1; cur = 1'b1;
        for (int c = 1; c <= v.exp_n * pe + 3; c++) begin
            @(negedge clk);
            if (bitStrobe) begin
                check($sformatf("v%0d_strobe_pos%0d", id, strobes), c, 1 + strobes * pe);
                if (sb.size() == 0) begin
                    check($sformatf("v%0d_extra_strobe", id), 1, 0);
                end else begin
                    cur = sb.pop_front();
                    check($sformatf("v%0d_bit%0d", id, strobes), dOut, cur);
                end
                strobes++;
            end else if (c <= v.exp_n * pe && dOut !== cur) begin
                hold_err++;
            end
            if (txDone && done_c < 0) begin
                done_c = c;
                check($sformatf("v%0d_done_dout", id), dOut, 1);
            end
            if (bitError) hold_err++;
        end
        check($sformatf("v%0d_done_cycle", id), done_c, v.exp_n * pe + 1);
        check($sformatf("v%0d_strobes", id), strobes, v.exp_n);
        check($sformatf("v%0d_hold", id), hold_err, 0);
        check($sformatf("v%0d_sb_left", id), sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   err_c, other, si, di;
        logic done_seen;
        int   exp_s[6];
        int   exp_d[2];
        logic e;

        tv[0] = '{23'd4, 128'b101,           8'd3,   8'd0,  3,   160'b101};
        tv[1] = '{23'd2, 128'd0,             8'd7,   8'd7,  8,   160'h20};
        tv[2] = '{23'd1, 128'h3F,            8'd6,   8'd5,  7,   160'h5F};
        tv[3] = '{23'd0, 128'b10,            8'd2,   8'd0,  2,   160'b10};
        tv[4] = '{23'd3, 128'd0,             8'd10,  8'd10, 12,  160'h820};
        tv[5] = '{23'd1, {4{32'hA5C30F96}},  8'd200, 8'd0,  128, {32'd0, {4{32'hA5C30F96}}}};
        tv[6] = '{23'd1, 128'h3F,            8'd6,   8'd50, 7,   160'h5F};
        tv[7] = '{23'd5, 128'hF0,            8'd8,   8'd0,  8,   160'hF0};

        resetN = 1'b0; txValid = 1'b0; bitPeriod = 23'd1; frameData = '0;
        frameLen = '0; stuffLen = '0; rx_force = 1'b0; rx_val = 1'b0;
        @(negedge clk);
        check("rst_dout", dOut, 1);
        check("rst_strobe", bitStrobe, 0);
        check("rst_done", txDone, 0);
        check("rst_err", bitError, 0);
        check("rst_ready", txReady, 1);
        resetN = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(tv[i], i);

        // readback error on bit 1
        @(negedge clk);
        bitPeriod = 23'd8; frameData = 128'b0010; frameLen = 8'd4; stuffLen = 8'd0;
        txValid = 1'b1;
        @(posedge clk);
        #1 txValid = 1'b0;
        err_c = -1; done_seen = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 9) begin rx_force = 1'b1; rx_val = 1'b0; end
            if (c == 20) rx_force = 1'b0;
            if (bitError && err_c < 0) err_c = c;
            if (c == 14) begin
                check("rb_dout", dOut, 1);
                check("rb_ready", txReady, 1);
            end
            if (txDone) done_seen = 1'b1;
        end
        check("rb_err_cycle", err_c, 14);
        check("rb_no_done", done_seen, 0);

        // asynchronous reset during bit 2
        @(negedge clk);
        bitPeriod = 23'd4; frameData = '0; frameLen = 8'd8; stuffLen = 8'd0;
        txValid = 1'b1;
        @(posedge clk);
        #1 txValid = 1'b0;
        for (int c = 1; c < 10; c++) @(negedge clk);
        check("mid_dout_before", dOut, 0);
        resetN = 1'b0;
        #1;
        check("mid_rst_dout", dOut, 1);
        check("mid_rst_ready", txReady, 1);
        other = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (txDone || bitError || bitStrobe) other++;
        end
        resetN = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (txDone || bitError || bitStrobe) other++;
        end
        check("mid_rst_quiet", other, 0);

        // back-to-back frames with txValid held
        exp_s = '{1, 3, 5, 8, 10, 12};
        exp_d = '{7, 14};
        sb.delete();
        bitPeriod = 23'd2; frameData = 128'b011; frameLen = 8'd3; stuffLen = 8'd0;
        txValid = 1'b1;
        for (int r = 0; r < 2; r++) begin
            sb.push_back(1'b1); sb.push_back(1'b1); sb.push_back(1'b0);
        end
        @(posedge clk);
        si = 0; di = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 8) txValid = 1'b0;
            if (bitStrobe) begin
                if (si < 6) check($sformatf("b2b_strobe%0d", si), c, exp_s[si]);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check($sformatf("b2b_bit%0d", si), dOut, e);
                end
                si++;
            end
            if (txDone) begin
                if (di < 2) check($sformatf("b2b_done%0d", di), c, exp_d[di]);
                di++;
            end
        end
        check("b2b_strobes", si, 6);
        check("b2b_dones", di, 2);

        // zero-length frame is ignored
        @(negedge clk);
        frameLen = 8'd0; bitPeriod = 23'd1; txValid = 1'b1;
        other = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bitStrobe || !txReady || dOut !== 1'b1) other++;
        end
        txValid = 1'b0;
        check("len0_ignored", other, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/can_bit_tx.md
# can_bit_tx

CAN bit-level transmitter: accepts a pre-assembled frame bit vector over a valid/ready handshake and drives it onto the bus output at a programmable bit period. Bit stuffing is applied over a programmable leading region of the frame. Each transmitted bit is read back at the mid-bit sample point, and the frame is aborted on mismatch. It is the transmit counterpart of the channel unit's receive synchroniser: it drives the line that the receive side synchronises and samples.

## Interface
- MAX_BITS, 128, width of the frame buffer (bits)
- LEN_W, 8, width of frameLen/stuffLen; 2^LEN_W-1 >= MAX_BITS
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- bitPeriod  in  23  clock cycles per bit; 0 treated as 1; latched at frame accept
- frameData  in  MAX_BITS  frame bits; frameData[0] transmitted first
- frameLen  in  LEN_W  number of unstuffed frame bits; values > MAX_BITS clamp to MAX_BITS
- stuffLen  in  LEN_W  number of leading frame bits subject to stuffing; clamps to frameLen
- txValid  in  1  frame request
- txReady  out  1  high exactly when state == IDLE
- rxIn  in  1  synchronised bus level for readback
- dOut  out  1  bus drive; 1 = recessive
- bitStrobe  out  1  one-cycle pulse in the first cycle of every transmitted bit, including stuff bits
- txDone  out  1  one-cycle pulse on successful completion
- bitError  out  1  one-cycle pulse on readback mismatch

## Operation
- States: IDLE, SEND, STUFF. SEND transmits a data bit. STUFF transmits an inserted bit.
- All outputs except txReady are registered.
- Reset values: dOut=1, bitStrobe=0, txDone=0, bitError=0, state=IDLE. txReady=1 while in reset.
- IDLE:
  - dOut=1.
  - Accept on txValid&&txReady with effective frameLen != 0.
  - On accept, latch frameData, the period P = max(bitPeriod,1), frameLen and stuffLen.
  - frameLen == 0 is ignored: no state change.
- Per-bit counter cnt runs 0..P-1. The bit value is driven for all P cycles.
- Readback:
  - rxIn is sampled when cnt == P>>1.
  - On rxIn != dOut, the next cycle has bitError=1, dOut=1 and state=IDLE. No txDone is issued and the latched frame is discarded.
- Stuffing:
  - A 3-bit run counter tracks consecutive identical transmitted bits.
  - The counter is active while the data index is < stuffLen, and for the one decision immediately after the last stuffed-region bit.
  - When the run reaches 5 at a bit end, the next bit is a stuff bit (complement of the last bit). It enters STUFF and does not advance the data index.
  - A stuff bit starts a new run of length 1.
  - Outside the region the run counter is held at 0 and no stuffing occurs.
- End of frame:
  - When the last data bit ends (cnt == P-1) and no stuff bit is pending, the next cycle has state=IDLE, dOut=1 and txDone=1.
  - The same cycle may accept a new frame (back-to-back).
- bitPeriod and frameData changes during a frame are ignored.
- Asynchronous reset mid-frame forces reset values immediately. No txDone or bitError is issued.

## Timing
- Accept at edge k. Cycle k+1: dOut = first bit, bitStrobe=1, cnt=0.
- Transmitted bit j (stuff bits included) occupies cycles k+1+jP .. k+(j+1)P.
- With N total transmitted bits, txDone=1 in cycle k+1+N·P.
- Readback mismatch on bit j: bitError=1 and dOut=1 in cycle k+1+jP+(P>>1)+1.
- P=1: every cycle is a bit boundary, and the sample point is cnt=0.
- Back-to-back: the txDone cycle is an IDLE cycle, so the minimum inter-frame gap is one recessive cycle.

## Test plan
- Basic send:
  - Stimulus: P=4, frameLen=3, frameData=3'b101, stuffLen=0, rxIn=dOut.
  - Response: dOut 1,0,1 for 4 cycles each; bitStrobe at k+1, k+5, k+9; txDone at k+13.
- Stuffing, zeros:
  - Stimulus: P=2, frameLen=7, all zeros, stuffLen=7.
  - Response: dOut 0,0,0,0,0,1,0,0; 8 bitStrobes; txDone at k+17.
- Stuffing at region boundary:
  - Stimulus: P=1, frameLen=6, all ones, stuffLen=5.
  - Response: dOut 1,1,1,1,1,0,1; txDone at k+8.
- Readback error:
  - Stimulus: P=8, frameData bit0=0, bit1=1, frameLen=4; rxIn forced 0 during bit 1.
  - Response: bitError=1 and dOut=1 at k+14; txReady=1 afterwards; no txDone.
- Reset mid-frame then back-to-back:
  - Stimulus: resetN low during bit 2, then two frames with txValid held high.
  - Response: dOut=1 asynchronously on reset; the second frame starts at txDone cycle+1.
- Degenerate inputs:
  - Stimulus: bitPeriod=0 with a 2-bit frame.
  - Response: P=1; txDone at k+3.
  - Stimulus: frameLen=0 with txValid=1.
  - Response: no bitStrobe, txReady stays 1.
